irig_b_symbol_encoder: RTL and testbench
========================================

IRIG_B_SYMBOL_ENCODER -- requirements
Module: irig_b_symbol_encoder

Interface
REQ-001 SHALL have parameter SYM_CYCLES, default 500_000: clocks per symbol (10 ms at 50 MHz).
REQ-002 SHALL have parameter HI_0, default 100_000: high-time in clocks of symbol '0'.
REQ-003 SHALL have parameter HI_1, default 250_000: high-time of symbol '1'.
REQ-004 SHALL have parameter HI_P, default 400_000: high-time of position marker 'P'.
REQ-005 SHALL have parameter CNT_W, default 20: symbol counter width; 2^CNT_W > SYM_CYCLES.
REQ-006 SHALL have parameter DEPTH, default 8, power of two: symbol FIFO depth; AW = log2(DEPTH).
REQ-007 SHALL require legal parameters 0 < HI_0 < HI_1 < HI_P < SYM_CYCLES.
REQ-008 clk  input  1  sole clock; all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 en  input  1  run enable.
REQ-011 invert  input  1  output polarity select; 1 inverts bcode_out.
REQ-012 sym_valid  input  1  symbol write request.
REQ-013 sym_code  input  2  00='0', 01='1', 10='P', 11=reserved.
REQ-014 sym_ready  output  1  FIFO can accept a symbol (= not full).
REQ-015 err_clr  input  1  clears sticky flags.
REQ-016 bcode_out  output  1  registered IRIG-B pulse stream.
REQ-017 sym_start  output  1  one-cycle pulse at first cycle of each emitted symbol.
REQ-018 busy  output  1  high while in RUN.
REQ-019 fifo_level  output  AW+1  current FIFO occupancy, 0..DEPTH.
REQ-020 underrun  output  1  sticky: a symbol slot found the FIFO empty.
REQ-021 code_err  output  1  sticky: reserved code 11 was emitted.

Function
REQ-022 Write: symbol SHALL be stored when sym_valid && sym_ready; sym_ready = (fifo_level != DEPTH); writes while full are ignored.
REQ-023 FSM SHALL have states IDLE and RUN; IDLE->RUN on edge where en=1; RUN->IDLE only at the edge ending a symbol (cnt == SYM_CYCLES-1) with en=0; mid-symbol en deassert finishes the current symbol.
REQ-024 In IDLE, cnt SHALL be 0 and bcode_out SHALL be invert (idle level low, non-inverted).
REQ-025 In RUN, cnt SHALL count 0..SYM_CYCLES-1 and wrap to 0; leaving RUN at wrap SHALL leave cnt 0.
REQ-026 Symbol load instant SHALL be the IDLE->RUN edge and every wrap edge that stays in RUN; at that edge the FIFO head SHALL be popped into cur_sym.
REQ-027 If the FIFO is empty at a load instant, cur_sym SHALL become EMPTY (all-low period) and underrun SHALL set; no bypass: a write in the same cycle is stored, not emitted.
REQ-028 Pop and write in the same cycle SHALL leave fifo_level unchanged.
REQ-029 bcode_out SHALL, on the edge where cnt becomes k, take (k < HI(cur_sym)) XOR invert, with HI('0')=HI_0, HI('1')=HI_1, HI('P')=HI_P, HI(11)=HI(EMPTY)=0; output is therefore aligned with cnt, zero extra latency.
REQ-030 Emitting code 11 SHALL set code_err at the load edge.
REQ-031 sym_start SHALL be 1 exactly on cycles where state=RUN and cnt=0.
REQ-032 Sticky flags: setting event SHALL win over err_clr in the same cycle.
REQ-033 invert change SHALL take effect on the next bcode_out update, without affecting counters.

Reset
REQ-034 rst=1 SHALL, at the next edge, force IDLE, cnt=0, FIFO empty (fifo_level=0), cur_sym=EMPTY, bcode_out=0, sym_start=0, busy=0, underrun=0, code_err=0; reset mid-symbol SHALL discard the symbol and the FIFO contents.
REQ-035 After rst deasserts, sym_ready SHALL be 1 on the first cycle.

Verification (SYM_CYCLES=10, HI_0=2, HI_1=5, HI_P=8, DEPTH=4, CNT_W=4)
REQ-036 Write '0','1','P', then en=1 -> bcode_out high 2/5/8 cycles of 10, sym_start every 10 cycles, fifo_level 3->0.
REQ-037 Write 4 symbols with en=0 -> sym_ready=0, fifo_level=4, 5th write ignored.
REQ-038 en=1 with empty FIFO -> bcode_out low 10 cycles, underrun=1 after first edge; err_clr clears it.
REQ-039 en dropped at cnt=3 of a 'P' symbol -> P completes (8 high, 2 low), then busy=0, bcode_out=0.
REQ-040 invert=1, symbol '1' -> bcode_out low 5 cycles, high 5; idle level 1.
REQ-041 Write code 11, run -> 10 low cycles, code_err=1; rst at cnt=4 -> all outputs at reset values next edge.

Source files
------------

// File: rtl/irig_b_symbol_encoder.sv
// -----------------------------------------------------------------------------
// irig_b_symbol_encoder
//   Turns a stream of queued IRIG-B symbols ('0', '1', 'P') into the pulse-width
//   coded bcode_out waveform. Each symbol lasts SYM_CYCLES clocks; the output is
//   high for the first HI_x clocks of the symbol and low for the rest.
//
// Parameters
//   SYM_CYCLES       clocks per symbol
//   HI_0/HI_1/HI_P   high time of '0' / '1' / 'P' (0 < HI_0 < HI_1 < HI_P < SYM_CYCLES)
//   CNT_W            symbol counter width (2**CNT_W > SYM_CYCLES)
//   DEPTH            symbol FIFO depth, power of two, >= 2
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   en                run enable; dropping it finishes the symbol in flight
//   invert            output polarity select
//   sym_valid/code    symbol write (00='0', 01='1', 10='P', 11=reserved)
//   sym_ready         FIFO not full
//   err_clr           clears the sticky flags
//   bcode_out         registered pulse stream
//   sym_start         pulse on the first cycle of each emitted symbol
//   busy              running
//   fifo_level        FIFO occupancy 0..DEPTH
//   underrun          sticky: a symbol slot found the FIFO empty
//   code_err          sticky: a reserved code was emitted
// -----------------------------------------------------------------------------
module irig_b_symbol_encoder #(
    parameter int unsigned SYM_CYCLES = 500_000,
    parameter int unsigned HI_0       = 100_000,
    parameter int unsigned HI_1       = 250_000,
    parameter int unsigned HI_P       = 400_000,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     invert,
    input  logic                     sym_valid,
    input  logic [1:0]               sym_code,
    output logic                     sym_ready,
    input  logic                     err_clr,
    output logic                     bcode_out,
    output logic                     sym_start,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     code_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Bit 2 marks the all-low filler used when the FIFO ran dry.
    typedef enum logic [2:0] {
        SYM_0     = 3'b000,
        SYM_1     = 3'b001,
        SYM_P     = 3'b010,
        SYM_RSVD  = 3'b011,
        SYM_EMPTY = 3'b100
    } sym_e;

    // High time of a symbol; reserved and filler symbols stay low all period.
    function automatic logic [CNT_W-1:0] hi_time(input sym_e s);
        logic [CNT_W-1:0] h;
        h = '0;
        case (s)
            SYM_0:   h = CNT_W'(HI_0);
            SYM_1:   h = CNT_W'(HI_1);
            SYM_P:   h = CNT_W'(HI_P);
            default: h = '0;
        endcase
        return h;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    sym_e              cur_sym_q, cur_sym_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_q, ready_d;
    logic              bcode_q, bcode_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic              code_err_q, code_err_d;
    logic [1:0]        mem_q [DEPTH];

    logic              push;
    logic              pop;
    logic              load;
    logic              fifo_empty;
    logic [1:0]        head;

    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign push       = sym_valid && ready_q;

    // Next-state: sequencing, symbol load, FIFO bookkeeping and output levels.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_sym_d  = cur_sym_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        load       = 1'b0;
        pop        = 1'b0;
        underrun_d = underrun_q && !err_clr;
        code_err_d = code_err_q && !err_clr;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(SYM_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (en) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Load pops the head; an empty FIFO yields a filler symbol, never a bypass.
        if (load) begin
            if (fifo_empty) begin
                cur_sym_d  = SYM_EMPTY;
                underrun_d = 1'b1;
            end else begin
                pop       = 1'b1;
                cur_sym_d = sym_e'({1'b0, head});
                rd_ptr_d  = rd_ptr_q + AW'(1);
                if (head == 2'b11) begin
                    code_err_d = 1'b1;
                end
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
        ready_d = (level_d != LW'(DEPTH));

        // Outputs track the counter value being entered, so no extra latency.
        busy_d  = (state_d == S_RUN);
        start_d = (state_d == S_RUN) && (cnt_d == '0);
        if (state_d == S_RUN) begin
            bcode_d = (cnt_d < hi_time(cur_sym_d)) ^ invert;
        end else begin
            bcode_d = invert;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_sym_q  <= SYM_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            bcode_q    <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_sym_q  <= cur_sym_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            bcode_q    <= bcode_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
            code_err_q <= code_err_d;
        end
    end

    // Symbol storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= sym_code;
        end
    end

    assign sym_ready  = ready_q;
    assign bcode_out  = bcode_q;
    assign sym_start  = start_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;
    assign code_err   = code_err_q;

endmodule

// File: tb/tb_irig_b_symbol_encoder.sv
// Bench for irig_b_symbol_encoder: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_irig_b_symbol_encoder;

    localparam int SYM   = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       invert = 1'b0;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_code = 2'b00;
    logic       err_clr = 1'b0;
    logic       sym_ready;
    logic       bcode_out;
    logic       sym_start;
    logic       busy;
    logic [2:0] fifo_level;
    logic       underrun;
    logic       code_err;

    int n_checks = 0;
    int n_errors = 0;

    irig_b_symbol_encoder #(
        .SYM_CYCLES(10), .HI_0(2), .HI_1(5), .HI_P(8), .CNT_W(4), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .invert(invert),
        .sym_valid(sym_valid), .sym_code(sym_code), .sym_ready(sym_ready),
        .err_clr(err_clr), .bcode_out(bcode_out), .sym_start(sym_start),
        .busy(busy), .fifo_level(fifo_level), .underrun(underrun),
        .code_err(code_err)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending symbols plus position inside the
    // symbol being transmitted.
    int  hi_tab [4] = '{2, 5, 8, 0};
    int  q [$];
    bit  m_run = 0;
    int  m_pos = 0;
    int  m_hi = 0;
    bit  m_out = 0;
    bit  m_start = 0;
    bit  m_ur = 0;
    bit  m_ce = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit push;
        bit load;
        bit ur_set;
        bit ce_set;
        int c;
        if (rst) begin
            m_run = 0; m_pos = 0; m_hi = 0; q.delete();
            m_out = 0; m_start = 0; m_ur = 0; m_ce = 0;
            return;
        end
        push = sym_valid && (q.size() < DEPTH);
        load = 0; ur_set = 0; ce_set = 0;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_pos = 0; load = 1;
            end
        end else if (m_pos == SYM - 1) begin
            m_pos = 0;
            if (en) load = 1;
            else m_run = 0;
        end else begin
            m_pos++;
        end
        if (load) begin
            if (q.size() > 0) begin
                c = q.pop_front();
                m_hi = hi_tab[c];
                if (c == 3) ce_set = 1;
            end else begin
                m_hi = 0;
                ur_set = 1;
            end
        end
        if (push) q.push_back(int'(sym_code));
        m_ur    = ur_set || (m_ur && !err_clr);
        m_ce    = ce_set || (m_ce && !err_clr);
        m_out   = m_run ? ((m_pos < m_hi) ^ invert) : invert;
        m_start = m_run && (m_pos == 0);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("bcode_out", 32'(bcode_out), 32'(m_out));
        check("sym_start", 32'(sym_start), 32'(m_start));
        check("busy", 32'(busy), 32'(m_run));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("sym_ready", 32'(sym_ready), 32'(q.size() != DEPTH));
        check("underrun", 32'(underrun), 32'(m_ur));
        check("code_err", 32'(code_err), 32'(m_ce));
    endtask

    task automatic wr(input logic [1:0] code);
        sym_valid = 1'b1; sym_code = code;
        cycle();
        sym_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(1);

        // '0','1','P' then run; then an empty slot and err_clr
        wr(2'b00); wr(2'b01); wr(2'b10);
        en = 1'b1;
        run(45);
        err_clr = 1'b1; run(1); err_clr = 1'b0;
        en = 1'b0;
        run(15);

        // Fill FIFO while idle, 5th write ignored, then drain
        wr(2'b01); wr(2'b00); wr(2'b10); wr(2'b01); wr(2'b00);
        run(2);
        en = 1'b1;
        run(40);
        en = 1'b0;
        run(12);

        // Drop en at cnt=3 of a 'P'
        wr(2'b10);
        en = 1'b1;
        run(4);
        en = 1'b0;
        run(15);

        // Inverted '1'
        invert = 1'b1;
        run(2);
        wr(2'b01);
        en = 1'b1;
        run(10);
        en = 1'b0;
        run(15);
        invert = 1'b0;

        // Reserved code, then reset mid-symbol
        wr(2'b11);
        en = 1'b1;
        run(5);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        en = 1'b0;
        run(3);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) invert = ~invert;
            err_clr   = ($urandom_range(0, 29) == 0);
            sym_valid = ($urandom_range(0, 5) == 0);
            sym_code  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
